// File: rtl/nn_pkg.sv
// Shared fixed-point constants and FSM state type for the dense forward/backward layers.
package nn_pkg;
    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam logic signed [DW-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DW-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/layer_backward_fxp_sat.sv
// Arithmetic right shift by FRAC (truncating toward -inf) followed by saturation to DW bits.
module fxp_sat
    import nn_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic signed [IN_W-1:0] din,
    output logic signed [DW-1:0]   dout
);
    localparam logic signed [IN_W-1:0] MAXV = IN_W'(SAT_MAX);
    localparam logic signed [IN_W-1:0] MINV = IN_W'(SAT_MIN);

    logic signed [IN_W-1:0] sh;

    always_comb begin
        sh = din >>> FRAC;
        if (sh > MAXV)      dout = SAT_MAX;
        else if (sh < MINV) dout = SAT_MIN;
        else                dout = sh[DW-1:0];
    end
endmodule

// File: rtl/layer_backward.sv
// Dense-layer backward pass: one column j per cycle produces dx[j] and dw[*][j];
// db is the ReLU-masked upstream gradient captured at start.
module layer_backward
    import nn_pkg::*;
#(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int RELU = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N*16-1:0]   x,
    input  logic [M*16-1:0]   y,
    input  logic [M*N*16-1:0] w,
    input  logic [M*16-1:0]   dy,
    output logic [N*16-1:0]   dx,
    output logic [M*N*16-1:0] dw,
    output logic [M*16-1:0]   db,
    output logic              busy,
    output logic              done
);
    localparam int JW = $clog2(N+1);
    localparam int AW = 32 + $clog2(M+1);

    state_t              state_q, state_d;
    logic [JW-1:0]       j_q, j_d;
    logic [N*DW-1:0]     x_q, x_d;
    logic [M*N*DW-1:0]   w_q, w_d;
    logic [M*DW-1:0]     g_q, g_d;
    logic [N*DW-1:0]     dx_q, dx_d;
    logic [M*N*DW-1:0]   dw_q, dw_d;
    logic [M*DW-1:0]     db_q, db_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [M*DW-1:0]        g_in;
    logic signed [DW-1:0]   x_col;
    logic [M*DW-1:0]        w_col;
    logic signed [2*DW-1:0] p_dw [M];
    logic signed [2*DW-1:0] p_dx [M];
    logic signed [AW-1:0]   acc;
    logic signed [DW-1:0]   dw_col [M];
    logic signed [DW-1:0]   dx_val;

    // ReLU derivative: y <= 0 (including exactly zero) kills the gradient
    always_comb begin
        g_in = '0;
        for (int i = 0; i < M; i++) begin
            if (RELU != 0 && $signed(y[DW*i +: DW]) <= 0) g_in[DW*i +: DW] = '0;
            else                                           g_in[DW*i +: DW] = dy[DW*i +: DW];
        end
    end

    always_comb begin
        x_col = '0;
        w_col = '0;
        for (int jj = 0; jj < N; jj++) begin
            if (j_q == JW'(jj)) begin
                x_col = x_q[DW*jj +: DW];
                for (int i = 0; i < M; i++) w_col[DW*i +: DW] = w_q[DW*(jj*M+i) +: DW];
            end
        end
    end

    // dw uses g*x, dx accumulates w*g down the column
    always_comb begin
        acc = '0;
        for (int i = 0; i < M; i++) begin
            p_dw[i] = $signed(g_q[DW*i +: DW]) * x_col;
            p_dx[i] = $signed(w_col[DW*i +: DW]) * $signed(g_q[DW*i +: DW]);
            acc     = acc + AW'(p_dx[i]);
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_dw_sat
        fxp_sat #(.IN_W(2*DW)) u_sat (.din(p_dw[gi]), .dout(dw_col[gi]));
    end

    fxp_sat #(.IN_W(AW)) u_dx_sat (.din(acc), .dout(dx_val));

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        x_d     = x_q;
        w_d     = w_q;
        g_d     = g_q;
        dx_d    = dx_q;
        dw_d    = dw_q;
        db_d    = db_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    w_d     = w;
                    g_d     = g_in;
                    db_d    = g_in;
                    j_d     = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int jj = 0; jj < N; jj++) begin
                    if (j_q == JW'(jj)) begin
                        dx_d[DW*jj +: DW] = dx_val;
                        for (int i = 0; i < M; i++) dw_d[DW*(jj*M+i) +: DW] = dw_col[i];
                    end
                end
                j_d = j_q + JW'(1);
                if (j_q == JW'(N-1)) state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            j_q     <= '0;
            x_q     <= '0;
            w_q     <= '0;
            g_q     <= '0;
            dx_q    <= '0;
            dw_q    <= '0;
            db_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            x_q     <= x_d;
            w_q     <= w_d;
            g_q     <= g_d;
            dx_q    <= dx_d;
            dw_q    <= dw_d;
            db_q    <= db_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dx   = dx_q;
    assign dw   = dw_q;
    assign db   = db_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
